// File: rtl/arb_pkg.sv
// Shared types and bit-manipulation helpers for the round-robin grant arbiter.
// Helpers operate on a 32-bit container, so requester counts up to 32 are supported.
package arb_pkg;

  localparam int unsigned ARB_MAX_N = 32;
  localparam int unsigned ARB_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Isolate the lowest set bit: vec & -vec.
  function automatic logic [ARB_MAX_N-1:0] lowest_one(input logic [ARB_MAX_N-1:0] vec);
    return vec & (-vec);
  endfunction

  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] vec);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(ARB_MAX_N); i++) begin
      if (vec[i]) idx = ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational lowest-set-bit isolator with an any-bit-set flag.
module priority_encoder
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_right_o,
  output logic              data_val_o
);

  assign data_right_o = DATA_W'(lowest_one(ARB_MAX_N'(data_i)));
  assign data_val_o   = |data_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: rotating-priority mask, grant held until done, withdrawal
// or hold-budget expiry, with one idle turnaround cycle between grants.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned REQ_N    = 4,
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned IDX_W    = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic [REQ_N-1:0] req_i,
  input  logic             done_i,
  output logic [REQ_N-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_val_o,
  output logic             timeout_o
);

  localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e           state_q, state_d;
  logic [REQ_N-1:0]     mask_q, mask_d;
  logic [REQ_N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 val_q, val_d;
  logic                 to_q, to_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [REQ_N-1:0]     masked_req, masked_low, raw_low, pick;
  logic                 masked_any, raw_any;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 rel_done, rel_drop, rel_hit;

  assign masked_req = req_i & mask_q;

  priority_encoder #(.DATA_W(REQ_N)) u_pe_masked (
    .data_i       (masked_req),
    .data_right_o (masked_low),
    .data_val_o   (masked_any)
  );

  priority_encoder #(.DATA_W(REQ_N)) u_pe_raw (
    .data_i       (req_i),
    .data_right_o (raw_low),
    .data_val_o   (raw_any)
  );

  // Fall back to the unmasked search when nobody above the last winner requests.
  assign pick     = masked_any ? masked_low : raw_low;
  assign pick_idx = onehot_to_idx(ARB_MAX_N'(pick));

  assign rel_done = done_i;
  assign rel_drop = ~|(req_i & grant_q);
  assign rel_hit  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    val_d   = val_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (raw_any) begin
          state_d = GRANT;
          grant_d = pick;
          idx_d   = IDX_W'(pick_idx);
          val_d   = 1'b1;
          cnt_d   = CNT_W'(1);
          for (int unsigned k = 0; k < REQ_N; k++) begin
            mask_d[k] = (k > 32'(pick_idx));
          end
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hit) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          val_d   = 1'b0;
          cnt_d   = '0;
          // Timeout is flagged only when the hold budget is the sole reason.
          to_d    = rel_hit && !rel_done && !rel_drop;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= IDLE;
      mask_q  <= '1;
      grant_q <= '0;
      idx_q   <= '0;
      val_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign grant_val_o = val_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter (REQ_N=4, MAX_HOLD=8): directed steps
// followed by random traffic, all compared against a round-robin reference model.
module tb_rr_grant_arbiter;

  localparam int N   = 4;
  localparam int HOLD = 8;

  logic         clk = 1'b0;
  logic         srst_n_i = 1'b0;
  logic [N-1:0] req_i = '0;
  logic         done_i = 1'b0;
  logic [N-1:0] grant_o;
  logic [1:0]   grant_idx_o;
  logic         grant_val_o;
  logic         timeout_o;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: current owner (-1 = none), last winner, cycles held.
  int own = -1;
  int last = N - 1;
  int held = 0;
  bit exp_to = 1'b0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.REQ_N(N), .MAX_HOLD(HOLD)) dut (
    .clk_i       (clk),
    .srst_n_i    (srst_n_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .grant_val_o (grant_val_o),
    .timeout_o   (timeout_o)
  );

  // Round-robin: first requester strictly after the last winner, circularly.
  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (from + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic d, input logic rs);
    exp_to = 1'b0;
    if (!rs) begin
      own = -1; last = N - 1; held = 0;
    end else if (own >= 0) begin
      if (d || !r[own] || held == HOLD) begin
        exp_to = (held == HOLD) && !d && r[own];
        own = -1; held = 0;
      end else begin
        held++;
      end
    end else begin
      own = rr_pick(r, last);
      if (own >= 0) begin
        last = own; held = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic d, input logic rs);
    req_i = r; done_i = d; srst_n_i = rs;
    @(posedge clk);
    model_edge(r, d, rs);
    #1;
    check("grant", 32'(grant_o), (own >= 0) ? (32'd1 << own) : 32'd0);
    check("val", 32'(grant_val_o), (own >= 0) ? 32'd1 : 32'd0);
    if (own >= 0) check("idx", 32'(grant_idx_o), 32'(own));
    check("timeout", 32'(timeout_o), 32'(exp_to));
  endtask

  initial begin
    logic [N-1:0] rr;
    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      check("rst_grant", 32'(grant_o), 32'd0);
    end
    check("rst_idx", 32'(grant_idx_o), 32'd0);
    step(4'b1111, 1'b0, 1'b1);
    check("first_grant", 32'(grant_o), 32'h1);
    check("first_idx", 32'(grant_idx_o), 32'd0);
    step(4'b1111, 1'b1, 1'b1);

    // Basic and wrap from reset.
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b1);
    check("basic_1", 32'(grant_o), 32'h2);
    step(4'b1010, 1'b1, 1'b1);
    check("turnaround", 32'(grant_val_o), 32'd0);
    step(4'b1010, 1'b0, 1'b1);
    check("basic_3", 32'(grant_o), 32'h8);
    step(4'b1010, 1'b1, 1'b1);
    step(4'b1010, 1'b0, 1'b1);
    check("wrap", 32'(grant_o), 32'h2);

    // Fairness with done asserted every cycle.
    step(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b1, 1'b1);

    // Hold-time budget expiry and regrant.
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 1'b0, 1'b1);
      if (i <= 8) begin
        check("hold_val", 32'(grant_val_o), (i < 8) ? 32'd1 : 32'd0);
        check("hold_to", 32'(timeout_o), (i == 8) ? 32'd1 : 32'd0);
      end
    end
    check("regrant", 32'(grant_o), 32'h1);

    // Withdrawal at cycle 3.
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    check("withdraw_to", 32'(timeout_o), 32'd0);

    // done coinciding with budget expiry.
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b0, 1'b1);
    step(4'b0001, 1'b1, 1'b1);
    check("coincide_to", 32'(timeout_o), 32'd0);

    // Reset mid-grant to idx 2.
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    check("midrst_val", 32'(grant_val_o), 32'd0);
    step(4'b0100, 1'b0, 1'b1);
    check("midrst_idx", 32'(grant_idx_o), 32'd2);
    step(4'b0101, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b1);
    check("mask_restored", 32'(grant_o), 32'h1);

    // Random traffic with sticky requests so timeouts occur.
    rr = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 20) rr = N'($urandom);
      step(rr, ($urandom_range(0, 99) < 15), ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
